// File: rtl/muntjac_bram_arbiter_if.sv
// Bundle of requester-side and BRAM-side signals for muntjac_bram_arbiter.
//
// Requester side : req_i / req_we_i / req_addr_i / req_wmask_i / req_wdata_i
//                  (packed, requester i in slice i), gnt_o, rsp_valid_o,
//                  rsp_rdata_o.
// BRAM side      : bram_en_o / bram_we_o / bram_addr_o / bram_wmask_o /
//                  bram_wdata_o, bram_rdata_i.
//
// Modports:
//   slave  - the arbiter's view (consumes requests and read data).
//   master - the environment's view (requesters plus the BRAM itself).
interface muntjac_bram_arbiter_if #(
   parameter int NumReq    = 2,
   parameter int AddrWidth = 53,
   parameter int DataWidth = 64
);
   localparam int MaskWidth = DataWidth / 8;

   logic [NumReq-1:0]           req_i;
   logic [NumReq-1:0]           req_we_i;
   logic [NumReq*AddrWidth-1:0] req_addr_i;
   logic [NumReq*MaskWidth-1:0] req_wmask_i;
   logic [NumReq*DataWidth-1:0] req_wdata_i;
   logic [NumReq-1:0]           gnt_o;
   logic [NumReq-1:0]           rsp_valid_o;
   logic [DataWidth-1:0]        rsp_rdata_o;
   logic                        bram_en_o;
   logic                        bram_we_o;
   logic [AddrWidth-1:0]        bram_addr_o;
   logic [MaskWidth-1:0]        bram_wmask_o;
   logic [DataWidth-1:0]        bram_wdata_o;
   logic [DataWidth-1:0]        bram_rdata_i;

   modport slave (
      input  req_i, req_we_i, req_addr_i, req_wmask_i, req_wdata_i, bram_rdata_i,
      output gnt_o, rsp_valid_o, rsp_rdata_o,
      output bram_en_o, bram_we_o, bram_addr_o, bram_wmask_o, bram_wdata_o
   );

   modport master (
      output req_i, req_we_i, req_addr_i, req_wmask_i, req_wdata_i, bram_rdata_i,
      input  gnt_o, rsp_valid_o, rsp_rdata_o,
      input  bram_en_o, bram_we_o, bram_addr_o, bram_wmask_o, bram_wdata_o
   );
endinterface

// File: rtl/muntjac_bram_arbiter.sv
// Round-robin sharing of one fixed-latency BRAM port among NumReq requesters.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   bus    - muntjac_bram_arbiter_if.slave: requests in, one-hot grant out
//            (same cycle), one-hot response strobe out ReadLatency cycles
//            after the grant, BRAM port out, BRAM read data in (passed
//            straight through as rsp_rdata_o).
//
// Every issued access (read or write) is tagged with the winner's index and
// carried down a ReadLatency-deep pipeline so the response strobe reaches the
// requester that issued it. The pipeline never stalls.
module muntjac_bram_arbiter #(
   parameter int NumReq      = 2,
   parameter int AddrWidth   = 53,
   parameter int DataWidth   = 64,
   parameter int ReadLatency = 1
) (
   input logic                   clk_i,
   input logic                   rst_i,
   muntjac_bram_arbiter_if.slave bus
);
   localparam int MaskWidth = DataWidth / 8;
   localparam int IdWidth   = (NumReq > 1) ? $clog2(NumReq) : 1;

   // Per-requester views of the packed payload buses.
   logic [AddrWidth-1:0] req_addr  [NumReq];
   logic [MaskWidth-1:0] req_wmask [NumReq];
   logic [DataWidth-1:0] req_wdata [NumReq];

   for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign req_addr[gi]  = bus.req_addr_i[gi*AddrWidth +: AddrWidth];
      assign req_wmask[gi] = bus.req_wmask_i[gi*MaskWidth +: MaskWidth];
      assign req_wdata[gi] = bus.req_wdata_i[gi*DataWidth +: DataWidth];
   end

   logic [IdWidth-1:0] rr_ptr_reg;
   logic [IdWidth-1:0] rr_ptr_next;
   logic [IdWidth-1:0] scan_idx;
   logic [IdWidth-1:0] winner;
   logic               any_req;
   logic               grant_valid;

   logic [ReadLatency-1:0]              pipe_valid_reg;
   logic [ReadLatency-1:0][IdWidth-1:0] pipe_id_reg;

   // Scan starting at rr_ptr; the first requester found wins.
   always_comb begin
      any_req  = 1'b0;
      winner   = '0;
      scan_idx = '0;
      for (int k = 0; k < NumReq; k++) begin
         scan_idx = IdWidth'((int'(rr_ptr_reg) + k) % NumReq);
         if (!any_req && bus.req_i[scan_idx]) begin
            any_req = 1'b1;
            winner  = scan_idx;
         end
      end
   end

   // Nothing is granted while reset is held, so no access is issued or tracked.
   assign grant_valid = any_req & ~rst_i;

   always_comb begin
      bus.gnt_o        = '0;
      bus.bram_en_o    = 1'b0;
      bus.bram_we_o    = 1'b0;
      bus.bram_addr_o  = '0;
      bus.bram_wmask_o = '0;
      bus.bram_wdata_o = '0;
      if (grant_valid) begin
         bus.gnt_o        = NumReq'(1) << winner;
         bus.bram_en_o    = 1'b1;
         bus.bram_we_o    = bus.req_we_i[winner];
         bus.bram_addr_o  = req_addr[winner];
         bus.bram_wmask_o = req_wmask[winner];
         bus.bram_wdata_o = req_wdata[winner];
      end
   end

   // After a grant the requester just served drops to lowest priority.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_valid) begin
         rr_ptr_next = (winner == IdWidth'(NumReq - 1)) ? '0 : winner + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_reg <= '0;
      end else begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // Response tracking: stage 0 captures this cycle's grant, later stages shift.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_valid_reg <= '0;
         pipe_id_reg    <= '0;
      end else begin
         pipe_valid_reg[0] <= grant_valid;
         pipe_id_reg[0]    <= winner;
         for (int k = 1; k < ReadLatency; k++) begin
            pipe_valid_reg[k] <= pipe_valid_reg[k-1];
            pipe_id_reg[k]    <= pipe_id_reg[k-1];
         end
      end
   end

   // In-flight responses are suppressed during the reset cycle as well.
   assign bus.rsp_valid_o = (pipe_valid_reg[ReadLatency-1] && !rst_i)
                          ? (NumReq'(1) << pipe_id_reg[ReadLatency-1]) : '0;
   assign bus.rsp_rdata_o = bus.bram_rdata_i;

endmodule
